input_entry_unit: RTL
=====================

Name: input_entry_unit

Overview:
- Upstream feeder for the integrate processor. Drives its enter and in1[7:0] inputs.
- Synchronises and debounces the raw board switches and enter pushbutton. Captures one byte per debounced press into a small FIFO.
- Presents the FIFO head to the processor. Pops the entry once the processor leaves its input state, so multiple entries queue up while the CPU is busy.

Parameters:
- DATA_W, 8: width of switch bus and in1.
- DEPTH, 4: FIFO entries; must be a power of 2, at least 2.
- DEB_CYCLES, 4: consecutive stable synchronised samples required before a button level change is accepted; at least 1.
- INPUT_STATE, 4'b1101: processor showstate code in which the processor samples enter/in1.

Ports:
- clock  in  1  system clock; all flops on rising edge.
- reset  in  1  asynchronous, active-low; clears everything.
- btn_raw  in  1  raw enter pushbutton, asynchronous, bouncy, 1 = pressed.
- sw_raw  in  DATA_W  raw data switches, asynchronous.
- cpu_state  in  4  processor showstate.
- enter  out  1  1 while FIFO non-empty; drives processor enter.
- in1  out  DATA_W  FIFO head byte; 0 when empty.
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; a press was dropped because the FIFO was full.

Behaviour:
Reset (reset = 0, asynchronous):
- Sync flops, debounce counter, FSM, FIFO pointers, count, overflow and prev_state all cleared.
- FSM returns to RELEASED. Outputs: enter = 0, in1 = 0, count = 0, full = 0, overflow = 0.
- Reset asserted mid-debounce or with data queued discards everything; no pop or push occurs in the release cycle.

Synchronisers:
- btn_raw and each sw_raw bit pass through 2 flops, giving btn_s and sw_s.
- Only btn_s and sw_s are used downstream.

Debounce FSM, 4 states:
- RELEASED: if btn_s = 1, go to PRESS_CHK with cnt = 1; else stay.
- PRESS_CHK:
  - btn_s = 0: back to RELEASED, cnt = 0.
  - btn_s = 1 and cnt == DEB_CYCLES: go to HELD and assert push for exactly that one cycle.
  - Otherwise cnt++.
- HELD: if btn_s = 0, go to RELEASE_CHK with cnt = 1.
- RELEASE_CHK:
  - btn_s = 1: back to HELD.
  - cnt == DEB_CYCLES: go to RELEASED.
  - Otherwise cnt++.
- Exactly one push per debounced press, however long the button is held. Glitches shorter than DEB_CYCLES samples produce no push.
- Push data is sw_s sampled in the push cycle.
- Latency: btn_raw stable-high edge to push = 2 + DEB_CYCLES clocks. Push to enter = 1 clock, because count is registered.

Pop:
- prev_state is cpu_state registered each clock.
- pop = (prev_state == INPUT_STATE) and (cpu_state != INPUT_STATE) and (count != 0).
- Exactly one pop per exit from INPUT_STATE.
- Exit from INPUT_STATE while the FIFO is empty: no action, no error.

FIFO:
- Write pointer, read pointer, and a count register.
- Push only: if not full, write and count++. If full, drop the data, count unchanged, set overflow.
- Pop only: read pointer advances, count--.
- Push and pop in the same cycle: both happen, count unchanged. This is legal even when full; no overflow.
- Pointers wrap modulo DEPTH.
- overflow clears only on reset.

Outputs:
- enter = (count != 0).
- in1 = mem[rd_ptr] when count != 0, else 0.
- Both are combinational from registers only; no path from raw inputs.

Test Plan:
1. Reset, then sw_raw = 8'h09, btn_raw held 1 for 20 clocks -> exactly one push; enter rises 2 + 4 + 1 = 7 clocks after btn_raw; in1 = 8'h09; count = 1.
2. Bounce: btn_raw toggles 1,0,1,0 on consecutive clocks, then 0 -> no push, count = 0, FSM back in RELEASED.
3. Four presses with bytes 8'h01, 8'h02, 8'h03, 8'h04, cpu_state held at 4'b0000 -> count = 4, full = 1, in1 = 8'h01. Fifth press with 8'h05 -> dropped, overflow = 1, count stays 4.
4. From a full FIFO, cycle cpu_state 4'b1101 -> 4'b1110 four times -> in1 sequence 8'h02, 8'h03, 8'h04, then 0. enter falls after the fourth exit. Repeat the exit with the FIFO empty -> no change.
5. Push and pop in the same clock (push cycle coincides with an INPUT_STATE exit) while count = 4 -> count stays 4, overflow unchanged, head advances, new byte is written at the tail.
6. Assert reset mid-PRESS_CHK with count = 2 -> all outputs 0 immediately (asynchronous). After release, the held button must be fully re-debounced before any push.

Source files
------------

// File: rtl/input_entry_unit.sv
// input_entry_unit: debounced switch-entry front end that queues bytes for the integrate processor
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   btn_raw   in   raw enter pushbutton, 1 = pressed
//   sw_raw    in   raw data switches
//   cpu_state in   processor showstate
//   enter     out  FIFO non-empty
//   in1       out  FIFO head byte, 0 when empty
//   count     out  FIFO occupancy
//   full      out  occupancy equals DEPTH
//   overflow  out  sticky, a press was dropped on a full FIFO
module input_entry_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 4,
    parameter int DEB_CYCLES = 4,
    parameter logic [3:0] INPUT_STATE = 4'b1101
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       btn_raw,
    input  logic [DATA_W-1:0]          sw_raw,
    input  logic [3:0]                 cpu_state,
    output logic                       enter,
    output logic [DATA_W-1:0]          in1,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {RELEASED, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    state_t              state;
    logic [DW-1:0]       cnt;
    logic                btn_m, btn_s;
    logic [DATA_W-1:0]   sw_m, sw_s;
    logic [3:0]          prev_state;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                push, pop, wr;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            sw_m  <= '0;
            sw_s  <= '0;
        end else begin
            btn_m <= btn_raw;
            btn_s <= btn_m;
            sw_m  <= sw_raw;
            sw_s  <= sw_m;
        end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            case (state)
                RELEASED:
                    if (btn_s) begin
                        state <= PRESS_CHK;
                        cnt   <= DW'(1);
                    end
                PRESS_CHK:
                    if (!btn_s) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == DEB_MAX) state <= HELD;
                    else cnt <= cnt + 1'b1;
                HELD:
                    if (!btn_s) begin
                        state <= RELEASE_CHK;
                        cnt   <= DW'(1);
                    end
                default:
                    if (btn_s) state <= HELD;
                    else if (cnt == DEB_MAX) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else cnt <= cnt + 1'b1;
            endcase
        end

    // push lasts only the single cycle in which PRESS_CHK hands over to HELD
    assign push = (state == PRESS_CHK) && btn_s && (cnt == DEB_MAX);
    assign pop  = (prev_state == INPUT_STATE) && (cpu_state != INPUT_STATE) && (count != '0);
    // a simultaneous pop frees the slot, so a full FIFO still accepts the write
    assign wr   = push && (!full || pop);

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            prev_state <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            prev_state <= cpu_state;
            if (wr) begin
                mem[wr_ptr] <= sw_s;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr && !pop) count <= count + 1'b1;
            else if (pop && !wr) count <= count - 1'b1;
            if (push && !wr) overflow <= 1'b1;
        end

    assign full  = (count == DEPTH_C);
    assign enter = (count != '0);
    assign in1   = enter ? mem[rd_ptr] : '0;
endmodule
